// File: rtl/xswitch_pkg.sv
// Shared types and sizing for the xswitch output arbiters.
// Optional build macro: XSWITCH_ARB_GRANT_CNT_EN adds per-output grant counters.
package xswitch_pkg;

    localparam int NUM_PORTS   = 4;
    localparam int ADDR_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int GRANT_CNT_W = 16;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    typedef logic [ADDR_W-1:0] port_idx_t;

    // Cyclic successor; explicit compare keeps non-power-of-2 port counts correct.
    function automatic port_idx_t next_idx(input port_idx_t idx);
        if (idx == port_idx_t'(NUM_PORTS - 1)) begin
            return port_idx_t'(0);
        end else begin
            return idx + port_idx_t'(1);
        end
    endfunction

endpackage

// File: rtl/xswitch_out_arbiter_if.sv
// Request/grant bundle between input queues, output arbiters and receivers.
// Optional build macro: XSWITCH_ARB_GRANT_CNT_EN adds the grant_cnt bus.
interface xswitch_out_arbiter_if;
    import xswitch_pkg::*;

    logic [NUM_PORTS-1:0]          valid_in;
    logic [NUM_PORTS*ADDR_W-1:0]   addr_in;
    logic [NUM_PORTS-1:0]          rcv_rdy;
    logic [NUM_PORTS-1:0]          data_read;
    logic [NUM_PORTS*ADDR_W-1:0]   out_sel;
    logic [NUM_PORTS-1:0]          data_rdy;
`ifdef XSWITCH_ARB_GRANT_CNT_EN
    logic [NUM_PORTS*GRANT_CNT_W-1:0] grant_cnt;

    modport master (output valid_in, addr_in, rcv_rdy,
                    input  data_read, out_sel, data_rdy, grant_cnt);
    modport slave  (input  valid_in, addr_in, rcv_rdy,
                    output data_read, out_sel, data_rdy, grant_cnt);
`else
    modport master (output valid_in, addr_in, rcv_rdy,
                    input  data_read, out_sel, data_rdy);
    modport slave  (input  valid_in, addr_in, rcv_rdy,
                    output data_read, out_sel, data_rdy);
`endif

endinterface

// File: rtl/xswitch_rr_arbiter.sv
// One output's round-robin arbiter: IDLE/GRANT FSM, rotating priority pointer, handshake.
// Optional build macro: XSWITCH_ARB_GRANT_CNT_EN adds a saturating transfer counter.
module xswitch_rr_arbiter
    import xswitch_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   req_i,
    input  logic                   rcv_rdy_i,
    output logic                   data_rdy_o,
    output port_idx_t              sel_o,
    output logic [NUM_PORTS-1:0]   read_o
`ifdef XSWITCH_ARB_GRANT_CNT_EN
    ,
    output logic [GRANT_CNT_W-1:0] grant_cnt_o
`endif
);

    arb_state_e state_q, state_d;
    port_idx_t  sel_q, sel_d;
    port_idx_t  rr_ptr_q, rr_ptr_d;
    logic       found_s;
    port_idx_t  grant_idx_s;
    logic       xfer_s;

    // Cyclic priority search starting at the rotating pointer
    always_comb begin
        port_idx_t cand;
        cand        = port_idx_t'(0);
        found_s     = 1'b0;
        grant_idx_s = port_idx_t'(0);
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = port_idx_t'((int'(rr_ptr_q) + k) % NUM_PORTS);
            if (!found_s && req_i[cand]) begin
                found_s     = 1'b1;
                grant_idx_s = cand;
            end else begin
                found_s     = found_s;
            end
        end
    end

    // A withdrawn or re-addressed request clears req_i[sel_q], so it never transfers
    assign xfer_s = (state_q == ARB_GRANT) && rcv_rdy_i && req_i[sel_q];

    // State, grant and pointer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ARB_IDLE;
            sel_q    <= port_idx_t'(0);
            rr_ptr_q <= port_idx_t'(0);
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (found_s) begin
                    state_d = ARB_GRANT;
                    sel_d   = grant_idx_s;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (xfer_s) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = next_idx(sel_q);
                end else if (!req_i[sel_q]) begin
                    state_d  = ARB_IDLE;
                end else begin
                    state_d  = ARB_GRANT;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        data_rdy_o     = (state_q == ARB_GRANT);
        sel_o          = sel_q;
        read_o         = {NUM_PORTS{1'b0}};
        read_o[sel_q]  = xfer_s;
    end

`ifdef XSWITCH_ARB_GRANT_CNT_EN
    logic [GRANT_CNT_W-1:0] grant_cnt_q;

    // Saturating count of completed transfers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_q <= 16'h0000;
        end else if (xfer_s && (grant_cnt_q != 16'hFFFF)) begin
            grant_cnt_q <= grant_cnt_q + 16'h0001;
        end else begin
            grant_cnt_q <= grant_cnt_q;
        end
    end

    assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: rtl/xswitch_out_arbiter.sv
// Crossbar output arbitration: one round-robin arbiter per output, acknowledges merged per input.
// Optional build macro: XSWITCH_ARB_GRANT_CNT_EN exposes per-output grant counters.
module xswitch_out_arbiter
    import xswitch_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    xswitch_out_arbiter_if.slave bus
);

    logic [NUM_PORTS-1:0] req_s  [NUM_PORTS];
    logic [NUM_PORTS-1:0] read_s [NUM_PORTS];
    logic                 rdy_s  [NUM_PORTS];
    port_idx_t            sel_s  [NUM_PORTS];
`ifdef XSWITCH_ARB_GRANT_CNT_EN
    logic [GRANT_CNT_W-1:0] cnt_s [NUM_PORTS];
`endif

    // Request matrix; out-of-range destinations match no output
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_s[o][i] = bus.valid_in[i] &&
                              (bus.addr_in[i*ADDR_W +: ADDR_W] == port_idx_t'(o));
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        xswitch_rr_arbiter u_arb (
            .clk        (clk),
            .reset      (reset),
            .req_i      (req_s[o]),
            .rcv_rdy_i  (bus.rcv_rdy[o]),
            .data_rdy_o (rdy_s[o]),
            .sel_o      (sel_s[o]),
            .read_o     (read_s[o])
`ifdef XSWITCH_ARB_GRANT_CNT_EN
            ,
            .grant_cnt_o(cnt_s[o])
`endif
        );
    end

    // Pack per-output results; each input addresses one output so the OR never collides
    always_comb begin
        logic [NUM_PORTS-1:0] rd;
        rd           = {NUM_PORTS{1'b0}};
        bus.out_sel  = {(NUM_PORTS*ADDR_W){1'b0}};
        bus.data_rdy = {NUM_PORTS{1'b0}};
`ifdef XSWITCH_ARB_GRANT_CNT_EN
        bus.grant_cnt = {(NUM_PORTS*GRANT_CNT_W){1'b0}};
`endif
        for (int o = 0; o < NUM_PORTS; o++) begin
            rd                                = rd | read_s[o];
            bus.out_sel[o*ADDR_W +: ADDR_W]   = sel_s[o];
            bus.data_rdy[o]                   = rdy_s[o];
`ifdef XSWITCH_ARB_GRANT_CNT_EN
            bus.grant_cnt[o*GRANT_CNT_W +: GRANT_CNT_W] = cnt_s[o];
`endif
        end
        if (reset) begin
            bus.data_read = rd;
        end else begin
            bus.data_read = {NUM_PORTS{1'b0}};
        end
    end

endmodule

// File: tb/tb_xswitch_out_arbiter.sv
// Self-checking bench for xswitch_out_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_xswitch_out_arbiter;
    import xswitch_pkg::*;

    localparam int N  = NUM_PORTS;
    localparam int AW = ADDR_W;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    xswitch_out_arbiter_if bus();

    xswitch_out_arbiter dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: per output a "holding a grant" flag, the granted input and the next-priority input
    int m_busy [N];
    int m_sel  [N];
    int m_ptr  [N];
    int m_cnt  [N];

    function automatic void m_reset();
        for (int o = 0; o < N; o++) begin
            m_busy[o] = 0; m_sel[o] = 0; m_ptr[o] = 0; m_cnt[o] = 0;
        end
    endfunction

    function automatic bit m_req(int o, int i);
        return bus.valid_in[i] && (int'(bus.addr_in[i*AW +: AW]) == o);
    endfunction

    function automatic logic [N-1:0] m_exp_rdy();
        logic [N-1:0] r = '0;
        for (int o = 0; o < N; o++) r[o] = (m_busy[o] != 0);
        return r;
    endfunction

    function automatic logic [N*AW-1:0] m_exp_sel();
        logic [N*AW-1:0] r = '0;
        for (int o = 0; o < N; o++) r[o*AW +: AW] = port_idx_t'(m_sel[o]);
        return r;
    endfunction

    function automatic logic [N-1:0] m_exp_read();
        logic [N-1:0] r = '0;
        for (int o = 0; o < N; o++)
            if (m_busy[o] != 0 && bus.rcv_rdy[o] && m_req(o, m_sel[o])) r[m_sel[o]] = 1'b1;
        return r;
    endfunction

    function automatic void m_tick();
        for (int o = 0; o < N; o++) begin
            if (m_busy[o] != 0) begin
                if (bus.rcv_rdy[o] && m_req(o, m_sel[o])) begin
                    m_ptr[o]  = (m_sel[o] + 1) % N;
                    m_busy[o] = 0;
                    if (m_cnt[o] < 65535) m_cnt[o] = m_cnt[o] + 1;
                end else if (!m_req(o, m_sel[o])) begin
                    m_busy[o] = 0;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (m_req(o, (m_ptr[o] + k) % N)) begin
                        m_busy[o] = 1;
                        m_sel[o]  = (m_ptr[o] + k) % N;
                        break;
                    end
                end
            end
        end
    endfunction

    task automatic set_req(int i, int a);
        bus.valid_in[i] = 1'b1;
        bus.addr_in[i*AW +: AW] = port_idx_t'(a);
    endtask

    task automatic clr_req(int i);
        bus.valid_in[i] = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.valid_in = '0;
        bus.addr_in  = '0;
        bus.rcv_rdy  = '0;
        next_cycle();
        reset = 1'b1;
        m_reset();
    endtask

    task automatic test_reset();
        bus.valid_in = '0; bus.addr_in = '0; bus.rcv_rdy = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.data_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0000", bus.data_rdy); end
        n_checks++; if (bus.out_sel !== 8'h00) begin n_fail++; $display("FAIL reset_sel: got %h expected 00", bus.out_sel); end
        n_checks++; if (bus.data_read !== 4'b0000) begin n_fail++; $display("FAIL reset_read: got %b expected 0000", bus.data_read); end
        next_cycle();
        set_req(0, 2); set_req(1, 2); bus.rcv_rdy = 4'b0100;
        repeat (3) next_cycle();
        // input 1 now holds output 2 with the pointer at 1; a transfer is due this cycle
        bus.rcv_rdy = 4'b1111;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        n_checks++; if (bus.data_rdy !== 4'b0000) begin n_fail++; $display("FAIL midreset_rdy: got %b expected 0000", bus.data_rdy); end
        n_checks++; if (bus.out_sel !== 8'h00) begin n_fail++; $display("FAIL midreset_sel: got %h expected 00", bus.out_sel); end
        n_checks++; if (bus.data_read !== 4'b0000) begin n_fail++; $display("FAIL midreset_read: got %b expected 0000", bus.data_read); end
        next_cycle();
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        n_checks++; if (bus.data_rdy !== 4'b0100) begin n_fail++; $display("FAIL postreset_rdy: got %b expected 0100", bus.data_rdy); end
        n_checks++; if (bus.out_sel[5:4] !== 2'd0) begin n_fail++; $display("FAIL postreset_sel2: got %0d expected 0", bus.out_sel[5:4]); end
        n_checks++; if (bus.data_read !== 4'b0001) begin n_fail++; $display("FAIL postreset_read: got %b expected 0001", bus.data_read); end
    endtask

    task automatic test_single();
        do_reset();
        set_req(2, 1); bus.rcv_rdy = 4'b0010;
        @(negedge clk);
        n_checks++; if (bus.data_rdy !== 4'b0000) begin n_fail++; $display("FAIL single_c0_rdy: got %b expected 0000", bus.data_rdy); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (bus.data_rdy !== 4'b0010) begin n_fail++; $display("FAIL single_c1_rdy: got %b expected 0010", bus.data_rdy); end
        n_checks++; if (bus.out_sel[3:2] !== 2'd2) begin n_fail++; $display("FAIL single_c1_sel: got %0d expected 2", bus.out_sel[3:2]); end
        n_checks++; if (bus.data_read !== 4'b0100) begin n_fail++; $display("FAIL single_c1_read: got %b expected 0100", bus.data_read); end
        next_cycle();
        clr_req(2);
        @(negedge clk);
        n_checks++; if (bus.data_rdy !== 4'b0000) begin n_fail++; $display("FAIL single_c2_rdy: got %b expected 0000", bus.data_rdy); end
    endtask

    task automatic test_contention();
        logic [3:0] exp_seq [10];
        exp_seq = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h2};
        do_reset();
        set_req(0, 0); set_req(1, 0); set_req(3, 0); bus.rcv_rdy = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.data_read !== exp_seq[c]) begin
                n_fail++; $display("FAIL contention_c%0d: got %b expected %b", c, bus.data_read, exp_seq[c]);
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        set_req(1, 3); bus.rcv_rdy = 4'b0000;
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++; if (bus.data_rdy !== 4'b1000) begin n_fail++; $display("FAIL bp_rdy_c%0d: got %b expected 1000", c, bus.data_rdy); end
            n_checks++; if (bus.out_sel[7:6] !== 2'd1) begin n_fail++; $display("FAIL bp_sel_c%0d: got %0d expected 1", c, bus.out_sel[7:6]); end
            n_checks++; if (bus.data_read !== 4'b0000) begin n_fail++; $display("FAIL bp_read_c%0d: got %b expected 0000", c, bus.data_read); end
            next_cycle();
        end
        bus.rcv_rdy = 4'b1000;
        @(negedge clk);
        n_checks++; if (bus.data_read !== 4'b0010) begin n_fail++; $display("FAIL bp_release_read: got %b expected 0010", bus.data_read); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (bus.data_read !== 4'b0000) begin n_fail++; $display("FAIL bp_bubble_read: got %b expected 0000", bus.data_read); end
        n_checks++; if (bus.data_rdy !== 4'b0000) begin n_fail++; $display("FAIL bp_bubble_rdy: got %b expected 0000", bus.data_rdy); end
        next_cycle();
        clr_req(1);
    endtask

    task automatic test_parallel();
        do_reset();
        set_req(0, 3); set_req(1, 2); set_req(2, 1); set_req(3, 0); bus.rcv_rdy = 4'b1111;
        next_cycle();
        @(negedge clk);
        n_checks++; if (bus.data_rdy !== 4'b1111) begin n_fail++; $display("FAIL parallel_rdy: got %b expected 1111", bus.data_rdy); end
        n_checks++; if (bus.out_sel !== 8'h1B) begin n_fail++; $display("FAIL parallel_sel: got %h expected 1b", bus.out_sel); end
        n_checks++; if (bus.data_read !== 4'b1111) begin n_fail++; $display("FAIL parallel_read: got %b expected 1111", bus.data_read); end
    endtask

    task automatic test_withdraw();
        do_reset();
        set_req(1, 0); bus.rcv_rdy = 4'b0001;
        next_cycle();
        @(negedge clk);
        n_checks++; if (bus.data_read !== 4'b0010) begin n_fail++; $display("FAIL wd_setup_read: got %b expected 0010", bus.data_read); end
        next_cycle();
        clr_req(1); set_req(2, 0); set_req(3, 0); bus.rcv_rdy = 4'b0000;
        next_cycle();
        @(negedge clk);
        n_checks++; if (bus.data_rdy[0] !== 1'b1 || bus.out_sel[1:0] !== 2'd2) begin n_fail++; $display("FAIL wd_grant: got rdy=%b sel=%0d expected rdy=1 sel=2", bus.data_rdy[0], bus.out_sel[1:0]); end
        next_cycle();
        clr_req(2); bus.rcv_rdy = 4'b0001;
        @(negedge clk);
        n_checks++; if (bus.data_read !== 4'b0000) begin n_fail++; $display("FAIL wd_noread: got %b expected 0000", bus.data_read); end
        next_cycle();
        set_req(2, 0);
        @(negedge clk);
        n_checks++; if (bus.data_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL wd_drop_rdy: got %b expected 0", bus.data_rdy[0]); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (bus.out_sel[1:0] !== 2'd2) begin n_fail++; $display("FAIL wd_regrant_sel: got %0d expected 2", bus.out_sel[1:0]); end
        n_checks++; if (bus.data_read !== 4'b0100) begin n_fail++; $display("FAIL wd_regrant_read: got %b expected 0100", bus.data_read); end
    endtask

    task automatic test_random();
        logic [N-1:0]    last_read = '0;
        logic [N-1:0]    e_rdy, e_read;
        logic [N*AW-1:0] e_sel;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (bus.valid_in[i]) begin
                    if (last_read[i]) begin
                        if ($urandom_range(0, 1) == 0) set_req(i, $urandom_range(0, N-1));
                        else clr_req(i);
                    end else if ($urandom_range(0, 19) == 0) begin
                        if ($urandom_range(0, 1) == 0) clr_req(i);
                        else set_req(i, $urandom_range(0, N-1));
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    set_req(i, $urandom_range(0, N-1));
                end
            end
            bus.rcv_rdy = 4'($urandom_range(0, 15));
            @(negedge clk);
            e_rdy = m_exp_rdy(); e_sel = m_exp_sel(); e_read = m_exp_read();
            n_checks++; if (bus.data_rdy !== e_rdy) begin n_fail++; $display("FAIL rand_rdy cyc%0d: got %b expected %b", cyc, bus.data_rdy, e_rdy); end
            n_checks++; if (bus.out_sel !== e_sel) begin n_fail++; $display("FAIL rand_sel cyc%0d: got %h expected %h", cyc, bus.out_sel, e_sel); end
            n_checks++; if (bus.data_read !== e_read) begin n_fail++; $display("FAIL rand_read cyc%0d: got %b expected %b", cyc, bus.data_read, e_read); end
`ifdef XSWITCH_ARB_GRANT_CNT_EN
            for (int o = 0; o < N; o++) begin
                n_checks++;
                if (bus.grant_cnt[o*16 +: 16] !== 16'(m_cnt[o])) begin
                    n_fail++; $display("FAIL rand_cnt%0d cyc%0d: got %0d expected %0d", o, cyc, bus.grant_cnt[o*16 +: 16], m_cnt[o]);
                end
            end
`endif
            last_read = e_read;
            @(posedge clk);
            m_tick();
            #1;
        end
    endtask

    initial begin
        bus.valid_in = '0;
        bus.addr_in  = '0;
        bus.rcv_rdy  = '0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_parallel();
        test_withdraw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xswitch_out_arbiter.md
Name: xswitch_out_arbiter

Overview:
Per-output round-robin arbiter and sequencer for the xswitch crossbar. Each input port presents a request with a destination address. For every output port, the block picks one requester and drives the crossbar source-select for that output. It runs the valid/ready handshake with the receiver and returns a one-cycle data_read acknowledge to the winning input. It sits between the input queues and the crossbar mux in the switch top.

Parameters:
NUM_PORTS, 4, number of input ports and number of output ports (square switch)
ADDR_W, $clog2(NUM_PORTS), width of one destination address / source index

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
valid_in  in  NUM_PORTS  per-input request valid
addr_in  in  NUM_PORTS*ADDR_W  per-input destination output index; slice i = input i
rcv_rdy  in  NUM_PORTS  per-output receiver ready
data_read  out  NUM_PORTS  per-input acknowledge; 1-cycle pulse when that input's word is accepted
out_sel  out  NUM_PORTS*ADDR_W  per-output crossbar source select; slice o = output o
data_rdy  out  NUM_PORTS  per-output data valid toward receiver

Behaviour:
- Reset (reset=0, async): data_rdy=0, out_sel=0, all rr_ptr=0, all FSMs in ARB_IDLE.
- data_read is combinational low during reset.
- Request matrix: req[o][i] = valid_in[i] && addr_in[i]==o.
- addr_in values >= NUM_PORTS are ignored and never granted.
- Each output o has an independent 2-state FSM plus rr_ptr[o] (ADDR_W bits).
- ARB_IDLE:
  - data_rdy[o]=0.
  - If any req[o][*] is set, grant the first i at or after rr_ptr[o], searching cyclically.
  - Register out_sel[o]=i and move to ARB_GRANT.
- ARB_GRANT:
  - data_rdy[o]=1 and out_sel[o] is held stable.
  - Transfer occurs in a cycle where data_rdy[o] && rcv_rdy[o] && valid_in[sel] && addr_in[sel]==o.
  - On transfer: data_read[sel]=1 combinationally in that cycle, rr_ptr[o] = (sel+1) mod NUM_PORTS, next state ARB_IDLE.
  - Withdraw: if valid_in[sel]=0 or addr_in[sel] changes while in ARB_GRANT, go to ARB_IDLE next cycle. No data_read is issued and rr_ptr is unchanged.
- Latency: request at cycle N gives data_rdy at N+1. With rcv_rdy=1, data_read also occurs at N+1 and data_rdy is low at N+2.
- Throughput: 1 word per 2 cycles per output; the mandatory IDLE bubble is intentional.
- Backpressure: rcv_rdy low holds ARB_GRANT indefinitely. No timeout.
- Requester protocol: valid_in and addr_in stay stable until data_read.
- Each input targets exactly one output, so at most one data_read bit per input per cycle.
- Different outputs arbitrate in parallel in the same cycle.
- Wrap-around: rr_ptr wraps from NUM_PORTS-1 to 0; non-power-of-2 NUM_PORTS is handled with explicit modulo.
- Reset mid-grant: immediate return to reset values. No data_read pulse is produced.

Optional Feature:
XSWITCH_ARB_GRANT_CNT_EN
- Defined:
  - Adds output port grant_cnt, NUM_PORTS*16 bits.
  - One 16-bit counter per output, incremented on every completed transfer.
  - Saturates at 16'hFFFF; cleared only by reset.
- Undefined: port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package xswitch_pkg:
  - NUM_PORTS default, ADDR_W.
  - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e.
  - typedef logic [ADDR_W-1:0] port_idx_t.
  - GRANT_CNT_W=16.
- Sub-module xswitch_rr_arbiter: one output's FSM, rr_ptr and cyclic priority search.
- xswitch_out_arbiter instantiates NUM_PORTS of them in a generate loop and ORs the per-output data_read contributions.

Test Plan:
- Reset: reset=0 mid-traffic -> data_rdy=0, out_sel=0 and data_read=0 immediately. First grant after release starts search at input 0.
- Single request: valid_in[2]=1, addr_in[2]=1, rcv_rdy[1]=1 at cycle 0 -> cycle 1: data_rdy[1]=1, out_sel[1]=2, data_read=4'b0100. Cycle 2: data_rdy[1]=0.
- Contention: inputs 0,1,3 all to output 0, held valid, rcv_rdy=1 -> data_read pulses on inputs 0,1,3,0,1 in that order, one every 2 cycles.
- Backpressure: input 1 to output 3, rcv_rdy[3]=0 for 5 cycles -> data_rdy[3]=1 and out_sel[3]=1 stable, no data_read. Raise rcv_rdy -> exactly one data_read[1] pulse.
- Parallel: input0->3, input1->2, input2->1, input3->0 simultaneously -> all data_rdy=4'b1111 on the same cycle; out_sel = {0,1,2,3} for outputs {3,2,1,0}.
- Withdraw: input 2 granted on output 0, valid_in[2] dropped before rcv_rdy -> data_rdy[0] low next cycle, no data_read[2]. rr_ptr[0] unchanged, so input 2 wins again on re-request.
